// File: rtl/alu_defs.sv
// Shared definitions for the execute-stage ALU: operation encodings,
// mul/div engine FSM states and a small op-classification helper.
package alu_defs;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_NOR   = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_MULT  = 4'd10,
    OP_MULTU = 4'd11,
    OP_DIV   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_MFHI  = 4'd14,
    OP_MFLO  = 4'd15
  } alu_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: one shift-add or restoring shift-subtract
// step per clock; HI/LO are written only on the final step.
module muldiv_iter
  import alu_defs::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic                  done_o,
  output md_state_e             state_o
);
  // Handshake: start_i with a mul/div op is taken only in IDLE (including the
  // done_o cycle); state_o==MD_RUN is the busy indication; done_o pulses for
  // exactly one cycle as HI/LO change; starts while running are dropped.
  localparam int W = DATA_WIDTH;
  localparam logic [SHAMT_WIDTH-1:0] LAST_STEP = SHAMT_WIDTH'(W - 1);

  md_state_e              state_q, state_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]           acc_q, acc_d, work_q, work_d, opb_q, opb_d;
  logic                   div_q, div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [W-1:0]           hi_q, hi_d, lo_q, lo_d;
  logic                   done_q, done_d;

  logic [W:0]     add_sum, shifted, diff;
  logic [W-1:0]   step_acc, step_lo, quo_fix, rem_fix;
  logic [2*W-1:0] prod, prod_fix;
  logic           sign_op, neg_a, neg_b;

  always_comb begin
    add_sum = {1'b0, acc_q} + (work_q[0] ? {1'b0, opb_q} : '0);
    shifted = {acc_q, work_q[W-1]};
    diff    = shifted - {1'b0, opb_q};
    if (div_q) begin
      if (diff[W]) begin
        step_acc = shifted[W-1:0];
        step_lo  = {work_q[W-2:0], 1'b0};
      end else begin
        step_acc = diff[W-1:0];
        step_lo  = {work_q[W-2:0], 1'b1};
      end
    end else begin
      step_acc = add_sum[W:1];
      step_lo  = {add_sum[0], work_q[W-1:1]};
    end
    prod     = {step_acc, step_lo};
    prod_fix = neg_res_q ? -prod : prod;
    // A zero divisor leaves the dividend magnitude in the remainder, so the
    // normal sign fix already yields HI = A; only LO needs overriding.
    quo_fix  = (opb_q == '0) ? '1 : (neg_res_q ? -step_lo : step_lo);
    rem_fix  = neg_rem_q ? -step_acc : step_acc;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    work_d    = work_q;
    opb_d     = opb_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    sign_op   = (op_i == OP_MULT) || (op_i == OP_DIV);
    neg_a     = sign_op & a_i[W-1];
    neg_b     = sign_op & b_i[W-1];
    case (state_q)
      MD_IDLE: begin
        if (start_i && is_muldiv(op_i)) begin
          state_d   = MD_RUN;
          cnt_d     = '0;
          acc_d     = '0;
          work_d    = neg_a ? -a_i : a_i;
          opb_d     = neg_b ? -b_i : b_i;
          div_d     = (op_i == OP_DIV) || (op_i == OP_DIVU);
          neg_res_d = neg_a ^ neg_b;
          neg_rem_d = neg_a;
        end
      end
      MD_RUN: begin
        acc_d  = step_acc;
        work_d = step_lo;
        cnt_d  = cnt_q + SHAMT_WIDTH'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          hi_d    = div_q ? rem_fix : prod_fix[2*W-1:W];
          lo_d    = div_q ? quo_fix : prod_fix[W-1:0];
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      work_q    <= '0;
      opb_q     <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      work_q    <= work_d;
      opb_q     <= opb_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Execute-stage ALU: combinational logic/arith/shift/compare ops with flags,
// plus the iterative mul/div engine whose busy output stalls the pipeline.
module alu_muldiv_seq
  import alu_defs::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             ALUOperation,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic                   start,
  output logic [DATA_WIDTH-1:0]  ALUResult,
  output logic                   Zero,
  output logic                   Overflow,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  HI,
  output logic [DATA_WIDTH-1:0]  LO
);
  localparam int W = DATA_WIDTH;

  md_state_e    md_state;
  logic [W-1:0] sum, dif, res;
  logic         ovf;

  muldiv_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start_i(start),
    .op_i   (ALUOperation),
    .a_i    (A),
    .b_i    (B),
    .hi_o   (HI),
    .lo_o   (LO),
    .done_o (done),
    .state_o(md_state)
  );

  assign busy = (md_state == MD_RUN);

  always_comb begin
    sum = A + B;
    dif = A - B;
    res = '0;
    ovf = 1'b0;
    case (ALUOperation)
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_NOR:  res = ~(A | B);
      OP_ADD: begin
        res = sum;
        ovf = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
      end
      OP_SUB: begin
        res = dif;
        ovf = (A[W-1] != B[W-1]) && (dif[W-1] != A[W-1]);
      end
      OP_SLL:  res = B << shamt;
      OP_SRL:  res = B >> shamt;
      OP_SRA:  res = $signed(B) >>> shamt;
      OP_SLT:  res = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: res = {{(W-1){1'b0}}, (A < B)};
      OP_MFHI: res = HI;
      OP_MFLO: res = LO;
      default: res = '0;
    endcase
  end

  assign ALUResult = res;
  assign Zero      = (res == '0);
  assign Overflow  = ovf;

endmodule
